sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single-port SRAM controller between two requesters: port 0 = IF stage, port 1 = MEM stage.
//  Round-robin arbitration, one transaction in flight; each requester sees a freeze-style ready.
//  Sits between the pipeline stages and the SRAM controller's memRead/memWrite/address/data/ready interface.
//  A watchdog prevents a hung controller from freezing the pipeline forever.
// PARAMETERS
//  ADDR_W   32   address width, all ports
//  DATA_W   32   data width, all ports
//  TIMEOUT  255  max GRANT cycles without mem_ready before abort; 0 = watchdog disabled
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-low
//  p0_rd      in   1       port 0 read request
//  p0_wr      in   1       port 0 write request
//  p0_addr    in   ADDR_W  port 0 address
//  p0_wdata   in   DATA_W  port 0 write data
//  p0_rdata   out  DATA_W  port 0 read data, registered
//  p0_ready   out  1       port 0 completion, 1-cycle pulse
//  p1_*       (same six signals for port 1)
//  mem_rd     out  1       read strobe to SRAM controller
//  mem_wr     out  1       write strobe to SRAM controller
//  mem_addr   out  ADDR_W  address to controller
//  mem_wdata  out  DATA_W  write data to controller
//  mem_rdata  in   DATA_W  read data from controller, valid while mem_ready=1
//  mem_ready  in   1       controller done; meaningful only while mem_rd|mem_wr
//  grant_id   out  1       port currently or last granted
//  busy       out  1       1 in GRANT and TURN states
//  err        out  1       sticky watchdog flag
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, last=1. All outputs 0: strobes, mem_addr/wdata, p*_rdata, p*_ready, grant_id, busy, err.
//  Reset mid-transaction drops strobes immediately. The transaction is lost and no ready pulse is sent.
//  States: IDLE -> GRANT -> TURN -> IDLE.
//  IDLE: sample requests; req_i = pi_rd|pi_wr.
//   - If only one port requests, grant it.
//   - If both request, grant !last.
//   - Registered at the edge: grant_id, mem_addr, mem_wdata, mem_wr=pi_wr, mem_rd=pi_rd&~pi_wr.
//   - Go to GRANT.
//  pi_rd & pi_wr together is treated as a write (write wins).
//  GRANT: strobes, addr and wdata are held constant. wdcnt increments every cycle.
//   - mem_ready=1: at the edge, latch mem_rdata into pi_rdata (reads only; writes leave pi_rdata unchanged).
//     Set pi_ready=1, clear strobes, last=grant_id, go to TURN.
//   - TIMEOUT!=0 and wdcnt==TIMEOUT-1 without mem_ready: same exit, but pi_rdata=0 on reads and err=1.
//  TURN: exactly one cycle. Strobes are 0 so the controller returns to idle.
//   - pi_ready is high this cycle only, then 0 -> IDLE.
//  Latency: request visible in cycle N -> strobes high from N+1.
//   - mem_ready in cycle M -> pi_ready high in M+1 -> next grant no earlier than strobes at M+3.
//  Requester rules:
//   - Hold rd/wr/addr/wdata stable up to and including the cycle its pi_ready is high.
//   - An inactive port's signals are ignored.
//  A request arriving while busy waits; it is not dropped. Requests are never queued beyond one per port.
//  pi_ready never asserts for the non-granted port. Both readies are never high in the same cycle.
//  wdcnt is width clog2(TIMEOUT+1). It clears on entering GRANT and does not wrap (exit happens first).
//  err clears only on reset.
// TESTING
//  T1 single read: p1_rd, addr 0x400, controller ready after 5 cycles with 0xDEADBEEF
//     -> mem_rd high 5 cycles, p1_rdata=0xDEADBEEF, p1_ready 1 pulse.
//  T2 simultaneous: p0_rd@0x0 and p1_wr@0x404/0x12345678 in the same cycle after reset
//     -> port 0 served first, port 1 next; mem_wr with 0x404/0x12345678; last=1.
//  T3 fairness: both ports request continuously for 6 transactions -> grant_id 0,1,0,1,0,1.
//  T4 watchdog: TIMEOUT=8, mem_ready held 0 on a p0_rd
//     -> strobes drop after 8 GRANT cycles, p0_ready pulses, p0_rdata=0, err=1 until reset.
//  T5 reset mid-GRANT: rst=0 while mem_wr=1
//     -> mem_wr=0 asynchronously, no pi_ready, first request after release is served normally.
//  T6 rd&wr both set on p0 -> mem_wr=1, mem_rd=0; p0_rdata unchanged after completion.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM controller between the IF (port 0)
// and MEM (port 1) stages, with one transaction in flight and a watchdog on the controller.
module sram_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic              p1_rd,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_id,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              grant_q, grant_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              p0_ready_q, p0_ready_d;
  logic              p1_ready_q, p1_ready_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wdcnt_q, wdcnt_d;

  logic              req0, req1, pick, wd_expired;
  logic [DATA_W-1:0] rd_result;

  assign req0       = p0_rd | p0_wr;
  assign req1       = p1_rd | p1_wr;
  assign wd_expired = (TIMEOUT != 0) && (wdcnt_q == WD_LAST);
  // An aborted read returns zero so the stage never consumes stale controller data
  assign rd_result  = mem_ready ? mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_ready_d  = 1'b0;
    p1_ready_d  = 1'b0;
    err_d       = err_q;
    wdcnt_d     = wdcnt_q;
    pick        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          pick        = (req0 && req1) ? ~last_q : req1;
          grant_d     = pick;
          mem_addr_d  = pick ? p1_addr : p0_addr;
          mem_wdata_d = pick ? p1_wdata : p0_wdata;
          mem_wr_d    = pick ? p1_wr : p0_wr;
          mem_rd_d    = pick ? (p1_rd & ~p1_wr) : (p0_rd & ~p0_wr);
          wdcnt_d     = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (wdcnt_q != '1) wdcnt_d = wdcnt_q + CNT_W'(1);
        if (mem_ready || wd_expired) begin
          if (mem_rd_q) begin
            if (grant_q) p1_rdata_d = rd_result;
            else         p0_rdata_d = rd_result;
          end
          if (grant_q) p1_ready_d = 1'b1;
          else         p0_ready_d = 1'b1;
          if (!mem_ready) err_d = 1'b1;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          last_d   = grant_q;
          state_d  = TURN;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_ready_q  <= 1'b0;
      p1_ready_q  <= 1'b0;
      err_q       <= 1'b0;
      wdcnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_ready_q  <= p0_ready_d;
      p1_ready_q  <= p1_ready_d;
      err_q       <= err_d;
      wdcnt_q     <= wdcnt_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_ready  = p0_ready_q;
  assign p1_ready  = p1_ready_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model that is compared with the DUT outputs on every falling edge.
module tb_sram_port_arbiter;

  localparam int TMO = 8;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          id;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  logic             clk;
  logic             rst;
  logic [1:0]       p_rd, p_wr, p_ready;
  logic [1:0][31:0] p_addr, p_wdata, p_rdata;
  logic             mem_rd, mem_wr, mem_ready;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic             grant_id, busy, err;

  int          tests = 0;
  int          fails = 0;
  int          force_lat = 0;
  bit          force_data_en = 0;
  logic [31:0] force_data = 32'h0;
  req_t        rq [2][$];
  grant_t      glog [$];
  int          strobe_cycles;
  int          ready_pulses [2];
  bit          prev_strobe = 0;
  bit          rst_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .p0_rd(p_rd[0]), .p0_wr(p_wr[0]), .p0_addr(p_addr[0]), .p0_wdata(p_wdata[0]),
    .p0_rdata(p_rdata[0]), .p0_ready(p_ready[0]),
    .p1_rd(p_rd[1]), .p1_wr(p_wr[1]), .p1_addr(p_addr[1]), .p1_wdata(p_wdata[1]),
    .p1_rdata(p_rdata[1]), .p1_ready(p_ready[1]),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mkReq(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  task automatic applyStimulus(input int port, input req_t r);
    p_rd[port]    = r.rd;
    p_wr[port]    = r.wr;
    p_addr[port]  = r.addr;
    p_wdata[port] = r.wdata;
  endtask

  // Controller stand-in: answers each strobe after a chosen number of GRANT cycles;
  // latencies above TMO never answer, which exercises the watchdog.
  initial begin : responder
    int cnt, lat;
    cnt = 0; lat = 1;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        cnt = 0; mem_ready = 1'b0;
      end else if (mem_rd || mem_wr) begin
        cnt++;
        if (cnt == 1) lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 11));
        mem_ready = (cnt == lat);
        mem_rdata = (mem_ready && force_data_en) ? force_data : $urandom;
      end else begin
        cnt = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Reference model: who is being served, how long, and who is owed a ready pulse.
  int               m_busy, m_ready, m_age;
  logic             m_last, m_gid, m_err, m_rd, m_wr;
  logic [31:0]      m_addr, m_wdata;
  logic [1:0][31:0] m_rdata;

  task automatic modelReset();
    m_busy = -1; m_ready = -1; m_age = 0;
    m_last = 1'b1; m_gid = 1'b0; m_err = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; m_rdata = '0;
  endtask

  task automatic modelStep();
    bit r0, r1;
    int w;
    if (m_ready >= 0) begin
      m_ready = -1;
    end else if (m_busy >= 0) begin
      m_age++;
      if (mem_ready || m_age == TMO) begin
        if (m_rd) m_rdata[m_busy] = mem_ready ? mem_rdata : 32'h0;
        if (!mem_ready) m_err = 1'b1;
        m_last  = (m_busy == 1);
        m_ready = m_busy;
        m_busy  = -1;
      end
    end else begin
      r0 = p_rd[0] | p_wr[0];
      r1 = p_rd[1] | p_wr[1];
      if (r0 || r1) begin
        w = (r0 && r1) ? (m_last ? 0 : 1) : (r1 ? 1 : 0);
        m_busy  = w;
        m_gid   = (w == 1);
        m_age   = 0;
        m_wr    = p_wr[w];
        m_rd    = p_rd[w] && !p_wr[w];
        m_addr  = p_addr[w];
        m_wdata = p_wdata[w];
      end
    end
  endtask

  always @(negedge clk) begin : compare
    if (!rst) begin
      rst_seen = 1'b1;
      modelReset();
    end
    if (rst_seen) begin
      checkOutput("mem_rd", mem_rd, (m_busy >= 0) && m_rd);
      checkOutput("mem_wr", mem_wr, (m_busy >= 0) && m_wr);
      if (!rst || m_busy >= 0) begin
        checkOutput("mem_addr", mem_addr, m_addr);
        checkOutput("mem_wdata", mem_wdata, m_wdata);
      end
      checkOutput("grant_id", grant_id, m_gid);
      checkOutput("busy", busy, (m_busy >= 0) || (m_ready >= 0));
      checkOutput("err", err, m_err);
      checkOutput("p0_ready", p_ready[0], m_ready == 0);
      checkOutput("p1_ready", p_ready[1], m_ready == 1);
      checkOutput("p0_rdata", p_rdata[0], m_rdata[0]);
      checkOutput("p1_rdata", p_rdata[1], m_rdata[1]);
      if (rst) modelStep();
    end
  end

  task automatic clearStats();
    glog.delete();
    strobe_cycles = 0;
    ready_pulses[0] = 0;
    ready_pulses[1] = 0;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    prev_strobe = 0;
  endtask

  // Requesters hold each request through its ready cycle, then take the next queued one.
  task automatic runTraffic(input int max_cycles, input bit gaps);
    bit active [2];
    bit drop [2];
    int cyc;
    grant_t g;
    active[0] = 0; active[1] = 0; drop[0] = 0; drop[1] = 0;
    cyc = 0;
    while ((rq[0].size() > 0 || rq[1].size() > 0 || active[0] || active[1]) && cyc < max_cycles) begin
      @(posedge clk); #1;
      cyc++;
      if ((mem_rd || mem_wr) && !prev_strobe) begin
        g.id = int'(grant_id); g.rd = mem_rd; g.wr = mem_wr;
        g.addr = mem_addr; g.wdata = mem_wdata;
        glog.push_back(g);
      end
      prev_strobe = mem_rd || mem_wr;
      if (prev_strobe) strobe_cycles++;
      for (int i = 0; i < 2; i++) begin
        if (p_ready[i]) ready_pulses[i]++;
        if (active[i] && p_ready[i]) begin
          drop[i] = 1;
        end else begin
          if (drop[i]) begin active[i] = 0; drop[i] = 0; end
          if (!active[i]) begin
            if (rq[i].size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
              applyStimulus(i, rq[i].pop_front());
              active[i] = 1;
            end else begin
              applyStimulus(i, mkReq(1'b0, 1'b0, $urandom, $urandom));
            end
          end
        end
      end
    end
    tests++;
    if (active[0] || active[1] || rq[0].size() > 0 || rq[1].size() > 0) begin
      fails++;
      $display("[TB] FAIL traffic_bound: requests still pending after %0d cycles, expected all served", max_cycles);
      rq[0].delete(); rq[1].delete();
    end
    applyStimulus(0, mkReq(1'b0, 1'b0, 32'h0, 32'h0));
    applyStimulus(1, mkReq(1'b0, 1'b0, 32'h0, 32'h0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin : main
    bit got;
    int op;
    rst = 1'b1;
    p_rd = '0; p_wr = '0; p_addr = '0; p_wdata = '0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_mem_rd", mem_rd, 0);
    checkOutput("rst_mem_wr", mem_wr, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_p_rdata0", p_rdata[0], 0);
    checkOutput("rst_p_rdata1", p_rdata[1], 0);
    checkOutput("rst_p_ready", 32'(p_ready), 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single read on port 1 answered on the fifth GRANT cycle
    clearStats();
    force_lat = 5; force_data_en = 1; force_data = 32'hDEADBEEF;
    rq[1].push_back(mkReq(1'b1, 1'b0, 32'h400, 32'h0));
    runTraffic(60, 0);
    checkOutput("t1_rd_cycles", strobe_cycles, 5);
    checkOutput("t1_grants", glog.size(), 1);
    if (glog.size() > 0) begin
      checkOutput("t1_grant_id", glog[0].id, 1);
      checkOutput("t1_addr", glog[0].addr, 32'h400);
      checkOutput("t1_is_rd", glog[0].rd, 1);
    end
    checkOutput("t1_rdata", p_rdata[1], 32'hDEADBEEF);
    checkOutput("t1_p1_pulses", ready_pulses[1], 1);
    checkOutput("t1_p0_pulses", ready_pulses[0], 0);

    // Simultaneous requests right after reset: port 0 first, then port 1's write
    doReset();
    clearStats();
    force_lat = 2; force_data = 32'hCAFEF00D;
    rq[0].push_back(mkReq(1'b1, 1'b0, 32'h0, 32'h0));
    rq[1].push_back(mkReq(1'b0, 1'b1, 32'h404, 32'h12345678));
    runTraffic(60, 0);
    checkOutput("t2_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      checkOutput("t2_first_id", glog[0].id, 0);
      checkOutput("t2_second_id", glog[1].id, 1);
      checkOutput("t2_second_wr", glog[1].wr, 1);
      checkOutput("t2_second_rd", glog[1].rd, 0);
      checkOutput("t2_second_addr", glog[1].addr, 32'h404);
      checkOutput("t2_second_wdata", glog[1].wdata, 32'h12345678);
    end
    checkOutput("t2_p0_rdata", p_rdata[0], 32'hCAFEF00D);
    checkOutput("t2_p1_rdata", p_rdata[1], 32'h0);

    // Continuous requests from both ports must alternate
    clearStats();
    force_lat = 0; force_data_en = 0;
    for (int k = 0; k < 3; k++) begin
      rq[0].push_back(mkReq(1'b1, 1'b0, $urandom, 32'h0));
      rq[1].push_back(mkReq(1'b1, 1'b0, $urandom, 32'h0));
    end
    runTraffic(200, 0);
    checkOutput("t3_grants", glog.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < glog.size()) checkOutput("t3_grant_order", glog[k].id, k % 2);

    // Read then rd&wr on port 0: the combined request is a write and keeps rdata
    clearStats();
    force_lat = 3; force_data_en = 1; force_data = 32'h11112222;
    rq[0].push_back(mkReq(1'b1, 1'b0, 32'h40, 32'h0));
    runTraffic(60, 0);
    checkOutput("t6_read_rdata", p_rdata[0], 32'h11112222);
    clearStats();
    force_data = 32'h99990000;
    rq[0].push_back(mkReq(1'b1, 1'b1, 32'h80, 32'h5555AAAA));
    runTraffic(60, 0);
    if (glog.size() > 0) begin
      checkOutput("t6_mem_wr", glog[0].wr, 1);
      checkOutput("t6_mem_rd", glog[0].rd, 0);
    end else begin
      checkOutput("t6_grants", glog.size(), 1);
    end
    checkOutput("t6_rdata_kept", p_rdata[0], 32'h11112222);

    // Controller never answers: watchdog aborts after TMO GRANT cycles
    clearStats();
    force_lat = 99; force_data_en = 0;
    rq[0].push_back(mkReq(1'b1, 1'b0, 32'h44, 32'h0));
    runTraffic(60, 0);
    checkOutput("t4_strobe_cycles", strobe_cycles, TMO);
    checkOutput("t4_rdata_zero", p_rdata[0], 32'h0);
    checkOutput("t4_err", err, 1);
    checkOutput("t4_p0_pulses", ready_pulses[0], 1);

    // Random traffic, including rd&wr and timeouts
    clearStats();
    force_lat = 0; force_data_en = 0;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 2; i++) begin
        op = int'($urandom_range(0, 3));
        rq[i].push_back(mkReq(op != 2, op >= 2, $urandom, $urandom));
      end
    end
    runTraffic(4000, 1);
    checkOutput("err_sticky", err, 1);

    // Reset in the middle of a write drops the strobe at once
    force_lat = 99;
    @(posedge clk); #1;
    applyStimulus(1, mkReq(1'b0, 1'b1, 32'h200, 32'h77778888));
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      got = mem_wr;
    end
    checkOutput("t5_mem_wr_high", mem_wr, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t5_async_wr_drop", mem_wr, 0);
    checkOutput("t5_async_busy", busy, 0);
    checkOutput("t5_no_ready", 32'(p_ready), 0);
    applyStimulus(1, mkReq(1'b0, 1'b0, 32'h0, 32'h0));
    repeat (2) @(negedge clk);
    checkOutput("t5_err_cleared", err, 0);
    checkOutput("t5_no_ready_held", 32'(p_ready), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    prev_strobe = 0;
    clearStats();
    force_lat = 4; force_data_en = 1; force_data = 32'h0BADF00D;
    rq[0].push_back(mkReq(1'b1, 1'b0, 32'h10, 32'h0));
    runTraffic(60, 0);
    checkOutput("t5_after_grants", glog.size(), 1);
    checkOutput("t5_after_rdata", p_rdata[0], 32'h0BADF00D);
    checkOutput("t5_after_p0_pulses", ready_pulses[0], 1);
    checkOutput("t5_after_p1_pulses", ready_pulses[1], 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
